// File: rtl/integration_controller_pkg.sv
// Shared FSM state encoding and index-width helper for the neuron integration controller.
// A width of at least one bit is kept even for single-entry tables.
package integration_controller_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_INTEG = 2'd2,
        S_EMIT  = 2'd3
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/integration_controller_weight_select.sv
// Picks the weight for one axon from the row's weight table by axon type.
// Combinational; the weight is forced to zero unless spike and synapse are both set.
module integration_controller_weight_select
    import integration_controller_pkg::*;
#(
    parameter int NUM_WEIGHTS  = 4,
    parameter int WEIGHT_WIDTH = 9
) (
    input  logic [idx_w(NUM_WEIGHTS)-1:0]        type_idx_i,
    input  logic                                 spike_i,
    input  logic                                 synapse_i,
    input  logic [NUM_WEIGHTS*WEIGHT_WIDTH-1:0]  weights_i,
    output logic [WEIGHT_WIDTH-1:0]              weight_o,
    output logic                                 hit_o
);

    localparam int TYPE_W = idx_w(NUM_WEIGHTS);

    logic [WEIGHT_WIDTH-1:0] sel;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_WEIGHTS; i++) begin
            if (type_idx_i == TYPE_W'(i)) begin
                sel = weights_i[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
        end
    end

    assign hit_o    = spike_i & synapse_i;
    assign weight_o = hit_o ? sel : '0;

endmodule

// File: rtl/integration_controller.sv
// Sequences one timestep: per neuron, read its row, stream every axon into the integrator, emit the result.
// Row memory is synchronous, so the first integrate cycle uses the live row and captures it for the rest.
module integration_controller
    import integration_controller_pkg::*;
#(
    parameter int NUM_AXONS       = 256,
    parameter int NUM_NEURONS     = 256,
    parameter int NUM_WEIGHTS     = 4,
    parameter int WEIGHT_WIDTH    = 9,
    parameter int POTENTIAL_WIDTH = 9
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 tick,
    input  logic [NUM_AXONS-1:0]                 axon_spikes,
    output logic [idx_w(NUM_NEURONS)-1:0]        csram_addr,
    output logic                                 csram_rd_en,
    input  logic [NUM_AXONS-1:0]                 csram_synapses,
    input  logic [NUM_WEIGHTS*WEIGHT_WIDTH-1:0]  csram_weights,
    input  logic [POTENTIAL_WIDTH-1:0]           csram_potential,
    output logic [idx_w(NUM_AXONS)-1:0]          axon_type_addr,
    input  logic [idx_w(NUM_WEIGHTS)-1:0]        axon_type,
    output logic                                 next_neuron,
    output logic                                 integrator_reg_en,
    output logic [WEIGHT_WIDTH-1:0]              weight,
    output logic [POTENTIAL_WIDTH-1:0]           current_potential,
    input  logic [POTENTIAL_WIDTH-1:0]           integrator_potential,
    output logic                                 neuron_done,
    output logic [idx_w(NUM_NEURONS)-1:0]        neuron_index,
    output logic [POTENTIAL_WIDTH-1:0]           neuron_potential,
    output logic                                 busy,
    output logic                                 step_done,
    output logic                                 overrun
);

    localparam int AXON_W = idx_w(NUM_AXONS);
    localparam int NEUR_W = idx_w(NUM_NEURONS);
    localparam logic [AXON_W-1:0] AXON_LAST = AXON_W'(NUM_AXONS - 1);
    localparam logic [NEUR_W-1:0] NEUR_LAST = NEUR_W'(NUM_NEURONS - 1);

    state_e                              state_q;
    logic [AXON_W-1:0]                   axon_q;
    logic [NEUR_W-1:0]                   neuron_q;
    logic [NUM_AXONS-1:0]                spikes_q;
    logic [NUM_AXONS-1:0]                syn_q;
    logic [NUM_WEIGHTS*WEIGHT_WIDTH-1:0] wts_q;
    logic [POTENTIAL_WIDTH-1:0]          pot_q;
    logic                                rd_en_q;
    logic                                done_q;
    logic                                step_done_q;
    logic                                busy_q;

    logic                                integ;
    logic                                first;
    logic                                hit;
    logic [NUM_AXONS-1:0]                syn_cur;
    logic [NUM_WEIGHTS*WEIGHT_WIDTH-1:0] wts_cur;
    logic [WEIGHT_WIDTH-1:0]             w_sel;

    assign integ   = (state_q == S_INTEG);
    assign first   = integ && (axon_q == '0);
    assign syn_cur = first ? csram_synapses : syn_q;
    assign wts_cur = first ? csram_weights  : wts_q;

    integration_controller_weight_select #(
        .NUM_WEIGHTS  (NUM_WEIGHTS),
        .WEIGHT_WIDTH (WEIGHT_WIDTH)
    ) u_weight_select (
        .type_idx_i (axon_type),
        .spike_i    (spikes_q[axon_q]),
        .synapse_i  (syn_cur[axon_q]),
        .weights_i  (wts_cur),
        .weight_o   (w_sel),
        .hit_o      (hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            axon_q      <= '0;
            neuron_q    <= '0;
            spikes_q    <= '0;
            syn_q       <= '0;
            wts_q       <= '0;
            pot_q       <= '0;
            rd_en_q     <= 1'b0;
            done_q      <= 1'b0;
            step_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rd_en_q     <= 1'b0;
            done_q      <= 1'b0;
            step_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tick) begin
                        spikes_q <= axon_spikes;
                        neuron_q <= '0;
                        rd_en_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= S_READ;
                    end
                end
                S_READ: begin
                    axon_q  <= '0;
                    state_q <= S_INTEG;
                end
                S_INTEG: begin
                    if (axon_q == '0) begin
                        syn_q <= csram_synapses;
                        wts_q <= csram_weights;
                        pot_q <= csram_potential;
                    end
                    if (axon_q == AXON_LAST) begin
                        done_q      <= 1'b1;
                        step_done_q <= (neuron_q == NEUR_LAST);
                        state_q     <= S_EMIT;
                    end else begin
                        axon_q <= axon_q + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (neuron_q == NEUR_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        neuron_q <= neuron_q + 1'b1;
                        rd_en_q  <= 1'b1;
                        state_q  <= S_READ;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Axon 0 always loads so the integrator starts from the stored potential.
    assign csram_rd_en       = rd_en_q;
    assign csram_addr        = rd_en_q ? neuron_q : '0;
    assign axon_type_addr    = integ ? axon_q : '0;
    assign next_neuron       = first;
    assign integrator_reg_en = first | (integ & hit);
    assign weight            = integ ? w_sel : '0;
    assign current_potential = integ ? (first ? csram_potential : pot_q) : '0;
    assign neuron_done       = done_q;
    assign neuron_index      = done_q ? neuron_q : '0;
    assign neuron_potential  = done_q ? integrator_potential : '0;
    assign busy              = busy_q;
    assign step_done         = step_done_q;
    assign overrun           = tick & busy_q;

endmodule
